hssl_link_ctrl: RTL and testbench

Bring-up and recovery sequencer for the HSSL transceiver channel that carries DVS events to the SpiNN-5 board.
- Drives the GT reset inputs and waits for tx/rx reset-done.
- Confirms comma alignment, then confirms the remote-peer handshake.
- Gates the outgoing event stream until the link is up.
- Monitors the live link and re-runs recovery on loss of sync, with bounded retries.
- Sits between the processor-side enable and the transceiver wrapper inside dvs_on_hssl_top.

---
 rtl/hssl_link_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_hssl_link_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hssl_link_ctrl.sv
// Bring-up / recovery sequencer for the HSSL transceiver channel: GT resets, alignment, handshake, tx gating.
// Optional link statistics (up/loss counters) are compiled in with `define HSSL_LINK_CTRL_STATS_EN.
module hssl_link_ctrl #(
    parameter int RST_HOLD_CYC     = 64,
    parameter int DONE_TIMEOUT     = 65536,
    parameter int ALIGN_STABLE_CYC = 16,
    parameter int ALIGN_TIMEOUT    = 4096,
    parameter int HSHAKE_TIMEOUT   = 65536,
    parameter int LOSS_CYC         = 8,
    parameter int MAX_RETRY        = 7,
    parameter int DW               = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable_in,
    input  logic          gt_tx_done_in,
    input  logic          gt_rx_done_in,
    input  logic          gt_aligned_in,
    input  logic          hshake_ok_in,
    output logic          gt_reset_all_out,
    output logic          gt_rx_reset_out,
    output logic          link_up_out,
    output logic          fail_out,
    output logic [2:0]    retry_cnt_out,
    output logic [2:0]    state_out,
    input  logic [DW-1:0] tx_data_in,
    input  logic          tx_vld_in,
    output logic          tx_rdy_out,
    output logic [DW-1:0] tx_data_out,
    output logic          tx_vld_out,
    input  logic          tx_rdy_in
`ifdef HSSL_LINK_CTRL_STATS_EN
    ,
    input  logic          stats_clr_in,
    output logic [15:0]   up_cnt_out,
    output logic [15:0]   loss_cnt_out
`endif
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RST_ALL     = 3'd1,
        WAIT_DONE   = 3'd2,
        WAIT_ALIGN  = 3'd3,
        WAIT_HSHAKE = 3'd4,
        LINK_UP     = 3'd5,
        RX_RST      = 3'd6,
        FAIL        = 3'd7
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared per-state timer covers every hold and timeout limit.
    localparam int TMR_MAX = max2(max2(RST_HOLD_CYC, DONE_TIMEOUT), max2(ALIGN_TIMEOUT, HSHAKE_TIMEOUT));
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int STAB_W  = $clog2(ALIGN_STABLE_CYC) + 1;
    localparam int LOSS_W  = $clog2(LOSS_CYC) + 1;

    localparam logic [TMR_W-1:0]  RST_LAST    = TMR_W'(RST_HOLD_CYC - 1);
    localparam logic [TMR_W-1:0]  DONE_LAST   = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  ALIGN_LAST  = TMR_W'(ALIGN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  HSHAKE_LAST = TMR_W'(HSHAKE_TIMEOUT - 1);
    localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(ALIGN_STABLE_CYC - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST   = LOSS_W'(LOSS_CYC - 1);
    localparam logic [2:0]        RETRY_MAX   = 3'(MAX_RETRY);

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [STAB_W-1:0]   stab_q, stab_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic [2:0]          retry_cnt_q, retry_cnt_d;
    logic                gt_reset_all_q, gt_reset_all_d;
    logic                gt_rx_reset_q, gt_rx_reset_d;
    logic                link_up_q, link_up_d;
    logic                fail_q, fail_d;
    logic                retry_req, rx_retry_req, loss_bad, state_chg;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        retry_cnt_d  = retry_cnt_q;
        retry_req    = 1'b0;
        rx_retry_req = 1'b0;
        loss_bad     = (state_q == LINK_UP) ? (!gt_aligned_in || !hshake_ok_in) : !gt_aligned_in;

        if (!enable_in) begin
            state_d = IDLE;
        end else begin
            // Success conditions are tested before timeouts so they win a tie.
            case (state_q)
                IDLE: begin
                    state_d     = RST_ALL;
                    retry_cnt_d = '0;
                end
                RST_ALL: begin
                    if (tmr_q == RST_LAST) state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (gt_tx_done_in && gt_rx_done_in) state_d = WAIT_ALIGN;
                    else if (tmr_q == DONE_LAST)        retry_req = 1'b1;
                end
                WAIT_ALIGN: begin
                    if (gt_aligned_in && stab_q == STAB_LAST) state_d = WAIT_HSHAKE;
                    else if (tmr_q == ALIGN_LAST)             rx_retry_req = 1'b1;
                end
                WAIT_HSHAKE: begin
                    if (hshake_ok_in) begin
                        state_d     = LINK_UP;
                        retry_cnt_d = '0;
                    end else if (loss_bad && loss_q == LOSS_LAST) begin
                        rx_retry_req = 1'b1;
                    end else if (tmr_q == HSHAKE_LAST) begin
                        retry_req = 1'b1;
                    end
                end
                LINK_UP: begin
                    if (loss_bad && loss_q == LOSS_LAST) rx_retry_req = 1'b1;
                end
                RX_RST: begin
                    if (tmr_q == RST_LAST) state_d = WAIT_DONE;
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (retry_req || rx_retry_req) begin
                if (retry_cnt_q == RETRY_MAX) begin
                    state_d = FAIL;
                end else begin
                    retry_cnt_d = retry_cnt_q + 3'd1;
                    state_d     = retry_req ? RST_ALL : RX_RST;
                end
            end
        end

        state_chg = (state_d != state_q);
        tmr_d     = state_chg ? '0 : ((&tmr_q) ? tmr_q : tmr_q + 1'b1);
        stab_d    = (state_chg || !gt_aligned_in) ? '0 : ((&stab_q) ? stab_q : stab_q + 1'b1);
        loss_d    = (state_chg || !loss_bad) ? '0 : ((&loss_q) ? loss_q : loss_q + 1'b1);

        // Outputs are decoded from the next state so they line up with state_out.
        gt_reset_all_d = (state_d == IDLE) || (state_d == RST_ALL) || (state_d == FAIL);
        gt_rx_reset_d  = (state_d == RX_RST);
        link_up_d      = (state_d == LINK_UP);
        fail_d         = (state_d == FAIL);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= IDLE;
            tmr_q          <= '0;
            stab_q         <= '0;
            loss_q         <= '0;
            retry_cnt_q    <= '0;
            gt_reset_all_q <= 1'b1;
            gt_rx_reset_q  <= 1'b0;
            link_up_q      <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            stab_q         <= stab_d;
            loss_q         <= loss_d;
            retry_cnt_q    <= retry_cnt_d;
            gt_reset_all_q <= gt_reset_all_d;
            gt_rx_reset_q  <= gt_rx_reset_d;
            link_up_q      <= link_up_d;
            fail_q         <= fail_d;
        end
    end

    assign gt_reset_all_out = gt_reset_all_q;
    assign gt_rx_reset_out  = gt_rx_reset_q;
    assign link_up_out      = link_up_q;
    assign fail_out         = fail_q;
    assign retry_cnt_out    = retry_cnt_q;
    assign state_out        = state_q;

    // Closed gate stalls upstream, so an unsent beat is simply held until the link returns.
    assign tx_vld_out  = link_up_q & tx_vld_in;
    assign tx_rdy_out  = link_up_q & tx_rdy_in;
    assign tx_data_out = tx_data_in;

`ifdef HSSL_LINK_CTRL_STATS_EN
    logic [15:0] up_cnt_q, up_cnt_d;
    logic [15:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        up_cnt_d   = up_cnt_q;
        loss_cnt_d = loss_cnt_q;
        if (stats_clr_in) begin
            up_cnt_d   = '0;
            loss_cnt_d = '0;
        end else begin
            if (state_d == LINK_UP && state_q != LINK_UP && up_cnt_q != 16'hFFFF)
                up_cnt_d = up_cnt_q + 16'd1;
            if (state_q == LINK_UP && state_d == RX_RST && loss_cnt_q != 16'hFFFF)
                loss_cnt_d = loss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            up_cnt_q   <= '0;
            loss_cnt_q <= '0;
        end else begin
            up_cnt_q   <= up_cnt_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign up_cnt_out   = up_cnt_q;
    assign loss_cnt_out = loss_cnt_q;
`endif

endmodule

// File: tb/tb_hssl_link_ctrl.sv
// Self-checking bench for hssl_link_ctrl: sequencing checks plus a tx-beat scoreboard.
module tb_hssl_link_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn, enable_in;
    logic          gt_tx_done_in, gt_rx_done_in, gt_aligned_in, hshake_ok_in;
    logic          gt_reset_all_out, gt_rx_reset_out, link_up_out, fail_out;
    logic [2:0]    retry_cnt_out, state_out;
    logic [DW-1:0] tx_data_in = '0;
    logic          tx_vld_in  = 1'b0;
    logic          tx_rdy_out, tx_vld_out, tx_rdy_in;
    logic [DW-1:0] tx_data_out;
`ifdef HSSL_LINK_CTRL_STATS_EN
    logic          stats_clr_in;
    logic [15:0]   up_cnt_out, loss_cnt_out;
`endif

    int            total = 0;
    int            bad   = 0;
    int            n_xfer = 0;
    logic [DW-1:0] sb_q[$];

    always #5 clk = ~clk;

    hssl_link_ctrl #(
        .RST_HOLD_CYC     (4),
        .DONE_TIMEOUT     (32),
        .ALIGN_STABLE_CYC (16),
        .ALIGN_TIMEOUT    (64),
        .HSHAKE_TIMEOUT   (128),
        .LOSS_CYC         (8),
        .MAX_RETRY        (7),
        .DW               (DW)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .enable_in        (enable_in),
        .gt_tx_done_in    (gt_tx_done_in),
        .gt_rx_done_in    (gt_rx_done_in),
        .gt_aligned_in    (gt_aligned_in),
        .hshake_ok_in     (hshake_ok_in),
        .gt_reset_all_out (gt_reset_all_out),
        .gt_rx_reset_out  (gt_rx_reset_out),
        .link_up_out      (link_up_out),
        .fail_out         (fail_out),
        .retry_cnt_out    (retry_cnt_out),
        .state_out        (state_out),
        .tx_data_in       (tx_data_in),
        .tx_vld_in        (tx_vld_in),
        .tx_rdy_out       (tx_rdy_out),
        .tx_data_out      (tx_data_out),
        .tx_vld_out       (tx_vld_out),
        .tx_rdy_in        (tx_rdy_in)
`ifdef HSSL_LINK_CTRL_STATS_EN
        ,
        .stats_clr_in     (stats_clr_in),
        .up_cnt_out       (up_cnt_out),
        .loss_cnt_out     (loss_cnt_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state_out != s && n < budget) begin
            tick();
            n++;
        end
        check(tag, state_out, s);
    endtask

    // Upstream source: expected beat is queued when driven, held until accepted.
    task automatic send_beat(input logic [DW-1:0] d, input int budget);
        sb_q.push_back(d);
        tx_data_in = d;
        tx_vld_in  = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_rdy_out) begin
                @(posedge clk);
                #1;
                tx_vld_in = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'd0, 32'd1);
        tx_vld_in = 1'b0;
    endtask

    // Downstream monitor: a beat moves on the edge after vld_out & rdy_in are seen.
    always @(negedge clk) begin
        if (resetn && tx_vld_out && tx_rdy_in) begin
            n_xfer++;
            if (sb_q.size() == 0) check("tx_extra_beat", sb_q.size(), 1);
            else                  check("tx_data", tx_data_out, sb_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_rst, up_tick, n_rx, n_ent;
        logic [2:0]  prev;

        resetn        = 1'b0;
        enable_in     = 1'b0;
        gt_tx_done_in = 1'b0;
        gt_rx_done_in = 1'b0;
        gt_aligned_in = 1'b0;
        hshake_ok_in  = 1'b0;
        tx_rdy_in     = 1'b1;
`ifdef HSSL_LINK_CTRL_STATS_EN
        stats_clr_in  = 1'b0;
`endif
        repeat (3) tick();
        check("rst_state",     state_out, 3'd0);
        check("rst_gt_all",    gt_reset_all_out, 1'b1);
        check("rst_gt_rx",     gt_rx_reset_out, 1'b0);
        check("rst_link",      link_up_out, 1'b0);
        check("rst_fail",      fail_out, 1'b0);
        check("rst_retry",     retry_cnt_out, 3'd0);
        check("rst_tx_rdy",    tx_rdy_out, 1'b0);
        check("rst_tx_vld",    tx_vld_out, 1'b0);
        resetn = 1'b1;

        fork
            send_beat(32'hDEAD_BEEF, 200);
        join_none
        tick();
        check("idle_state", state_out, 3'd0);
        check("idle_gate_vld", tx_vld_out, 1'b0);

        // Bring-up: done 10 cycles after RST_ALL entry, handshake after 20.
        gt_aligned_in = 1'b1;
        enable_in     = 1'b1;
        n_rst   = 0;
        up_tick = 0;
        for (int t = 1; t <= 60 && up_tick == 0; t++) begin
            tick();
            if (state_out == 3'd1 && gt_reset_all_out) n_rst++;
            if (t == 10) begin
                check("gate_vld_down", tx_vld_out, 1'b0);
                check("gate_rdy_down", tx_rdy_out, 1'b0);
            end
            if (t == 11) begin
                gt_tx_done_in = 1'b1;
                gt_rx_done_in = 1'b1;
            end
            if (t == 21) hshake_ok_in = 1'b1;
            if (link_up_out) up_tick = t;
        end
        check("rst_all_hold",  n_rst, 4);
        check("linkup_tick",   up_tick, 29);
        check("linkup_state",  state_out, 3'd5);
        check("linkup_retry",  retry_cnt_out, 3'd0);
        check("linkup_gt_all", gt_reset_all_out, 1'b0);
        repeat (5) tick();
        check("beat1_once", n_xfer, 1);
        check("beat1_vld_low", tx_vld_out, 1'b0);

        // Glitches one cycle short of LOSS_CYC are ignored.
        gt_aligned_in = 1'b0;
        repeat (7) tick();
        gt_aligned_in = 1'b1;
        repeat (3) tick();
        check("glitch_align_state", state_out, 3'd5);
        hshake_ok_in = 1'b0;
        repeat (7) tick();
        hshake_ok_in = 1'b1;
        repeat (3) tick();
        check("glitch_hs_link", link_up_out, 1'b1);

        // Sustained loss triggers rx-only recovery.
        gt_aligned_in = 1'b0;
        repeat (8) tick();
        check("loss_state",  state_out, 3'd6);
        check("loss_link",   link_up_out, 1'b0);
        check("loss_rx_rst", gt_rx_reset_out, 1'b1);
        check("loss_retry",  retry_cnt_out, 3'd1);
        fork
            send_beat(32'hCAFE_F00D, 200);
        join_none
        gt_aligned_in = 1'b1;
        n_rx = 1;
        for (int t = 0; t < 20 && state_out == 3'd6; t++) begin
            tick();
            if (state_out == 3'd6 && gt_rx_reset_out) n_rx++;
        end
        check("rx_rst_hold", n_rx, 4);
        check("gate_recover", tx_vld_out, 1'b0);
        wait_state(3'd5, 60, "relink_state");
        check("relink_retry", retry_cnt_out, 3'd0);
        repeat (4) tick();
        check("beat2_once", n_xfer, 2);

        // Retry exhaustion: done never arrives.
        enable_in = 1'b0;
        tick();
        check("dis_state",  state_out, 3'd0);
        check("dis_gt_all", gt_reset_all_out, 1'b1);
        check("dis_link",   link_up_out, 1'b0);
        gt_tx_done_in = 1'b0;
        gt_rx_done_in = 1'b0;
        gt_aligned_in = 1'b0;
        hshake_ok_in  = 1'b0;
        enable_in     = 1'b1;
        n_ent = 0;
        prev  = 3'd0;
        for (int t = 0; t < 1000 && !fail_out; t++) begin
            tick();
            if (state_out == 3'd1 && prev != 3'd1) n_ent++;
            prev = state_out;
        end
        check("fail_flag",       fail_out, 1'b1);
        check("fail_retry",      retry_cnt_out, 3'd7);
        check("fail_state",      state_out, 3'd7);
        check("fail_gt_all",     gt_reset_all_out, 1'b1);
        check("rst_all_entries", n_ent, 8);
        repeat (5) tick();
        check("fail_hold", state_out, 3'd7);
        enable_in = 1'b0;
        tick();
        check("fail_exit_state", state_out, 3'd0);
        check("fail_exit_flag",  fail_out, 1'b0);

        // Restart; done arrives on the very cycle the timeout expires.
        enable_in = 1'b1;
        tick();
        check("restart_state", state_out, 3'd1);
        check("restart_retry", retry_cnt_out, 3'd0);
        wait_state(3'd2, 20, "restart_wait_done");
        repeat (31) tick();
        gt_tx_done_in = 1'b1;
        gt_rx_done_in = 1'b1;
        tick();
        check("tie_state", state_out, 3'd3);
        check("tie_retry", retry_cnt_out, 3'd0);

        // Reset while waiting for the handshake.
        gt_aligned_in = 1'b1;
        wait_state(3'd4, 40, "hs_state");
        resetn = 1'b0;
        tick();
        check("midrst_state",  state_out, 3'd0);
        check("midrst_gt_all", gt_reset_all_out, 1'b1);
        check("midrst_gt_rx",  gt_rx_reset_out, 1'b0);
        check("midrst_link",   link_up_out, 1'b0);
        check("midrst_fail",   fail_out, 1'b0);
        check("midrst_retry",  retry_cnt_out, 3'd0);
        check("midrst_tx_rdy", tx_rdy_out, 1'b0);
`ifdef HSSL_LINK_CTRL_STATS_EN
        check("midrst_up_cnt", up_cnt_out, 16'd0);
`endif
        resetn       = 1'b1;
        hshake_ok_in = 1'b1;
        wait_state(3'd5, 100, "post_rst_up");

        for (int k = 0; k < 3; k++) begin
            gt_aligned_in = 1'b0;
            repeat (8) tick();
            check("cyc_loss_state", state_out, 3'd6);
            gt_aligned_in = 1'b1;
            wait_state(3'd5, 60, "cyc_relink");
        end
`ifdef HSSL_LINK_CTRL_STATS_EN
        check("stats_up",   up_cnt_out, 16'd4);
        check("stats_loss", loss_cnt_out, 16'd3);
`endif

        // Disable during rx-only reset.
        gt_aligned_in = 1'b0;
        repeat (8) tick();
        check("rxrst_state", state_out, 3'd6);
        enable_in = 1'b0;
        tick();
        check("rxrst_dis_state",  state_out, 3'd0);
        check("rxrst_dis_gt_rx",  gt_rx_reset_out, 1'b0);
        check("rxrst_dis_gt_all", gt_reset_all_out, 1'b1);

`ifdef HSSL_LINK_CTRL_STATS_EN
        stats_clr_in = 1'b1;
        tick();
        stats_clr_in = 1'b0;
        check("stats_clr_up",   up_cnt_out, 16'd0);
        check("stats_clr_loss", loss_cnt_out, 16'd0);
`endif

        repeat (3) tick();
        check("sb_empty",    sb_q.size(), 0);
        check("beats_total", n_xfer, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
